// File: rtl/hex_display_pkg.sv
// Shared types and the active-low hex font for the 7-segment scanner.
// Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
package hex_display_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic seg_t nibble_to_seg(input logic [3:0] nibble);
    return FONT[nibble];
  endfunction

endpackage

// File: rtl/hex_seg_lut.sv
// Combinational nibble-to-segment decode with blanking when the digit is off.
module hex_seg_lut
  import hex_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_en,
  output seg_t       o_seg
);

  assign o_seg = i_en ? nibble_to_seg(i_nibble) : SEG_BLANK;

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed common-anode 7-segment driver with frame-synchronous,
// double-buffered updates. Optional blinking is enabled by HEX_DISPLAY_BLINK_EN.
module hex_display_scanner
  import hex_display_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     digit_en,
`ifdef HEX_DISPLAY_BLINK_EN
  input  logic [DIGITS-1:0]     blink_mask,
`endif
  output logic                  pending,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(SCAN_DIV - 1);

  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [4*DIGITS-1:0]   r_sh_val;
  logic [DIGITS-1:0]     r_sh_en;
  logic [4*DIGITS-1:0]   r_act_val;
  logic [DIGITS-1:0]     r_act_en;
  logic                  r_pending;
  logic [DIGITS-1:0]     r_an;
  seg_t                  r_seg;

  logic                  w_wrap;
  logic                  w_frame_end;
  logic [3:0]            w_nib;
  logic                  w_lit;
  logic [DIGITS-1:0]     w_an;
  seg_t                  w_seg;

`ifdef HEX_DISPLAY_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] LAST_FRM = BW'(BLINK_DIV - 1);

  logic [DIGITS-1:0]     r_sh_blink;
  logic [DIGITS-1:0]     r_act_blink;
  logic [BW-1:0]         r_frm;
  logic                  r_phase;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sh_blink  <= '0;
      r_act_blink <= '0;
      r_frm       <= '0;
      r_phase     <= 1'b0;
    end else begin
      if (w_frame_end) begin
        r_frm <= (r_frm == LAST_FRM) ? '0 : r_frm + 1'b1;
        if (r_frm == LAST_FRM) r_phase <= ~r_phase;
      end
      if (w_frame_end && load) begin
        r_sh_blink  <= blink_mask;
        r_act_blink <= blink_mask;
      end else if (w_frame_end && r_pending) begin
        r_act_blink <= r_sh_blink;
      end else if (load) begin
        r_sh_blink  <= blink_mask;
      end
    end
  end
`endif

  assign w_wrap      = (r_cnt == LAST_CNT);
  assign w_frame_end = w_wrap && (r_idx == LAST_IDX);

  // Select the scanned digit with constant part-selects so any DIGITS works.
  always_comb begin
    w_nib = 4'h0;
    w_lit = 1'b0;
    w_an  = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nib = r_act_val[i*4 +: 4];
`ifdef HEX_DISPLAY_BLINK_EN
        w_lit = r_act_en[i] && !(r_phase && r_act_blink[i]);
`else
        w_lit = r_act_en[i];
`endif
        w_an[i] = ~w_lit;
      end
    end
  end

  hex_seg_lut u_lut (
    .i_nibble (w_nib),
    .i_en     (w_lit),
    .o_seg    (w_seg)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_sh_val  <= '0;
      r_sh_en   <= '0;
      r_act_val <= '0;
      r_act_en  <= '0;
      r_pending <= 1'b0;
      r_an      <= '1;
      r_seg     <= SEG_BLANK;
    end else begin
      if (w_wrap) begin
        r_cnt <= '0;
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      // A load landing on the frame end goes straight to the active copy.
      if (w_frame_end && load) begin
        r_sh_val  <= value;
        r_sh_en   <= digit_en;
        r_act_val <= value;
        r_act_en  <= digit_en;
        r_pending <= 1'b0;
      end else if (w_frame_end && r_pending) begin
        r_act_val <= r_sh_val;
        r_act_en  <= r_sh_en;
        r_pending <= 1'b0;
      end else if (load) begin
        r_sh_val  <= value;
        r_sh_en   <= digit_en;
        r_pending <= 1'b1;
      end

      // Dead time on every index change keeps the previous digit from ghosting.
      if (w_wrap) begin
        r_an  <= '1;
        r_seg <= SEG_BLANK;
      end else begin
        r_an  <= w_an;
        r_seg <= w_seg;
      end
    end
  end

  assign pending    = r_pending;
  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_done = w_frame_end;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner (DIGITS=4, SCAN_DIV=4): reset, scan,
// double-buffering, coincident load, digit enables and mid-frame reset.
module tb_hex_display_scanner;

  logic        clk;
  logic        reset_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  digit_en;
  logic        pending;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;
`ifdef HEX_DISPLAY_BLINK_EN
  logic [3:0]  blink_mask;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int frame_id = 0;

  hex_display_scanner #(
    .DIGITS    (4),
    .SCAN_DIV  (4),
    .BLINK_DIV (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .value      (value),
    .digit_en   (digit_en),
`ifdef HEX_DISPLAY_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .pending    (pending),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frame_done();
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(posedge clk); #1;
      load = 1'b0;
      if (frame_done) seen = 1'b1;
    end
    chk("frame_done_timeout", {31'd0, seen}, 32'd1);
  endtask

  // Walks one 16-cycle frame from cycle c_start, checking every output each
  // cycle; optionally drives up to two load strobes right after cycles lc0/lc1.
  task automatic check_frame(input int c_start, input logic [27:0] segs, input logic [3:0] en,
                             input int lc0, input logic [15:0] lv0, input logic [3:0] le0,
                             input int lc1, input logic [15:0] lv1, input logic [3:0] le1);
    logic       pend;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    int         d;
    int         p;
    pend = 1'b0;
    frame_id++;
    for (int c = c_start; c < 16; c++) begin
      @(posedge clk); #1;
      load = 1'b0;
      d = c / 4;
      p = c % 4;
      if (p != 0 && en[d]) begin
        e_an  = ~(4'b0001 << d);
        e_seg = segs[d*7 +: 7];
      end else begin
        e_an  = 4'hF;
        e_seg = 7'h7F;
      end
      chk($sformatf("f%0d_c%0d_an", frame_id, c), {28'd0, an}, {28'd0, e_an});
      chk($sformatf("f%0d_c%0d_seg", frame_id, c), {25'd0, seg}, {25'd0, e_seg});
      chk($sformatf("f%0d_c%0d_frame_done", frame_id, c), {31'd0, frame_done}, (c == 15) ? 32'd1 : 32'd0);
      chk($sformatf("f%0d_c%0d_pending", frame_id, c), {31'd0, pending}, {31'd0, pend});
      if (c == lc0) begin
        load = 1'b1; value = lv0; digit_en = le0;
        if (c != 15) pend = 1'b1;
      end
      if (c == lc1) begin
        load = 1'b1; value = lv1; digit_en = le1;
        if (c != 15) pend = 1'b1;
      end
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    load     = 1'b0;
    value    = '0;
    digit_en = '0;
`ifdef HEX_DISPLAY_BLINK_EN
    blink_mask = '0;
`endif

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rst%0d_seg", i), {25'd0, seg}, 32'h7F);
      chk($sformatf("rst%0d_an", i), {28'd0, an}, 32'hF);
      chk($sformatf("rst%0d_pending", i), {31'd0, pending}, 32'd0);
      chk($sformatf("rst%0d_frame_done", i), {31'd0, frame_done}, 32'd0);
    end
    reset_n = 1'b1;

    @(posedge clk); #1;
    load = 1'b1; value = 16'h12AF; digit_en = 4'hF;
    @(posedge clk); #1;
    load = 1'b0;
    chk("load_pending", {31'd0, pending}, 32'd1);
    wait_frame_done();
    chk("pending_at_frame_end", {31'd0, pending}, 32'd1);

    // 12AF: digit0=F, digit1=A, digit2=2, digit3=1
    check_frame(0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    // current frame untouched while two loads queue up; last one wins
    check_frame(0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF, 5, 16'h0000, 4'hF, 9, 16'h3333, 4'hF);
    // all '3'; load coincident with frame_done at cycle 15
    check_frame(0, {4{7'h30}}, 4'hF, 15, 16'h5555, 4'hF, -1, 16'h0, 4'h0);
    // all '5'; queue sparse enables
    check_frame(0, {4{7'h12}}, 4'hF, 3, 16'h8421, 4'b0101, -1, 16'h0, 4'h0);
    // digits 0 ('1') and 2 ('4') only
    check_frame(0, {7'h7F, 7'h19, 7'h7F, 7'h79}, 4'b0101, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    // reset during digit 2's slot with an uncommitted load outstanding
    for (int c = 0; c <= 9; c++) begin
      @(posedge clk); #1;
      load = 1'b0;
      if (c == 2) begin
        load = 1'b1; value = 16'hAAAA; digit_en = 4'hF;
      end
    end
    chk("pre_reset_pending", {31'd0, pending}, 32'd1);
    chk("pre_reset_an", {28'd0, an}, 32'hB);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_an", {28'd0, an}, 32'hF);
    chk("midrst_seg", {25'd0, seg}, 32'h7F);
    chk("midrst_pending", {31'd0, pending}, 32'd0);
    chk("midrst_frame_done", {31'd0, frame_done}, 32'd0);
    reset_n = 1'b1;

    // scan restarts at digit 0, blank; queue digit1='C'
    check_frame(1, 28'h0, 4'h0, 4, 16'h00C0, 4'b0010, -1, 16'h0, 4'h0);
    check_frame(0, {7'h7F, 7'h7F, 7'h46, 7'h7F}, 4'b0010, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
